// File: rtl/dm_pkg.sv
// dm_burst_ctrl shared types and constants.
// Widths, FSM states and table reset value.
package dm_pkg;

    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int LW   = 8;
    localparam int NPTR = 4;
    localparam int PW   = $clog2(NPTR);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } dm_state_t;

    typedef logic [AW-1:0] dm_addr_t;

    localparam dm_addr_t TBL_RST = '0;

endpackage

// File: rtl/dm_target_table.sv
// Run-time programmable burst base-address table.
// One write port, one combinational read port.
module dm_target_table
    import dm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_idx,
    input  dm_addr_t      wr_data,
    input  logic [PW-1:0] rd_idx,
    output dm_addr_t      rd_data
);

    dm_addr_t tbl_q [NPTR];
    dm_addr_t tbl_d [NPTR];

    // Next table contents: single-entry update on write.
    always_comb begin
        tbl_d = tbl_q;
        if (wr_en) begin
            tbl_d[wr_idx] = wr_data;
        end
    end

    // Table storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPTR; i++) begin
                tbl_q[i] <= TBL_RST;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // Reads see the pre-write value of a same-cycle update.
    assign rd_data = tbl_q[rd_idx];

endmodule

// File: rtl/dm_burst_ctrl.sv
// Burst sequencer between core load/store and DataMem.
// Table-based base address, 2-entry read FIFO.
module dm_burst_ctrl
    import dm_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CfgWe,
    input  logic [PW-1:0] CfgIdx,
    input  logic [AW-1:0] CfgData,
    input  logic          Start,
    input  logic [PW-1:0] Ptr,
    input  logic [LW-1:0] Len,
    input  logic          Dir,
    input  logic [DW-1:0] InData,
    input  logic          InValid,
    output logic          InReady,
    output logic [DW-1:0] OutData,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [AW-1:0] DmAddr,
    output logic          DmRdEn,
    output logic          DmWrEn,
    output logic [DW-1:0] DmWrData,
    input  logic [DW-1:0] DmRdData,
    output logic          Busy,
    output logic          Done
);

    dm_state_t     state_q, state_d;
    dm_addr_t      base_q, base_d;
    dm_addr_t      tbl_rd;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] off_q, off_d;
    logic          dir_q, dir_d;
    logic          infl_q, infl_d;
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [1:0]    cnt_q, cnt_d;

    logic          rd_en;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic          last;

    dm_target_table u_tbl (
        .clk     (Clk),
        .rst_n   (Reset),
        .wr_en   (CfgWe),
        .wr_idx  (CfgIdx),
        .wr_data (CfgData),
        .rd_idx  (Ptr),
        .rd_data (tbl_rd)
    );

    // Access qualifiers; a same-cycle pop frees a FIFO slot.
    always_comb begin
        push  = infl_q;
        pop   = (cnt_q != 2'd0) && OutReady;
        wr_en = (state_q == RUN) && dir_q && InValid;
        rd_en = (state_q == RUN) && !dir_q &&
                ((cnt_q + {1'b0, infl_q} - {1'b0, pop}) < 2'd2);
        last  = (off_q == (len_q - LW'(1)));
    end

    // Read-data FIFO and in-flight tracking.
    always_comb begin
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        infl_d = rd_en;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wp_q] = DmRdData;
            wp_d        = ~wp_q;
        end
        if (pop) begin
            rp_d = ~rp_q;
        end
    end

    // Burst FSM next state and latched burst parameters.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        dir_d   = dir_q;
        off_d   = off_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    base_d  = tbl_rd;
                    len_d   = Len;
                    dir_d   = Dir;
                    off_d   = '0;
                    state_d = (Len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_en || wr_en) begin
                    off_d = off_q + LW'(1);
                    if (last) begin
                        state_d = dir_q ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst and FIFO registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            dir_q    <= 1'b0;
            off_q    <= '0;
            infl_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            off_q   <= off_d;
            infl_q  <= infl_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign DmRdEn   = rd_en;
    assign DmWrEn   = wr_en;
    assign DmAddr   = (rd_en || wr_en) ? (base_q + dm_addr_t'(off_q)) : '0;
    assign DmWrData = wr_en ? InData : '0;
    assign InReady  = (state_q == RUN) && dir_q;
    assign OutValid = (cnt_q != 2'd0);
    assign OutData  = OutValid ? mem_q[rp_q] : '0;
    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);

endmodule

// File: tb/tb_dm_burst_ctrl.sv
// Directed bench for dm_burst_ctrl.
// DataMem model, stream source, event logs.
module tb_dm_burst_ctrl;
    import dm_pkg::*;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          CfgWe = 1'b0;
    logic [1:0]    CfgIdx = '0;
    logic [9:0]    CfgData = '0;
    logic          Start = 1'b0;
    logic [1:0]    Ptr = '0;
    logic [7:0]    Len = '0;
    logic          Dir = 1'b0;
    logic [7:0]    InData;
    logic          InValid;
    logic          InReady;
    logic [7:0]    OutData;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [9:0]    DmAddr;
    logic          DmRdEn;
    logic          DmWrEn;
    logic [7:0]    DmWrData;
    logic [7:0]    DmRdData = '0;
    logic          Busy;
    logic          Done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    int wr_addr[$], wr_dat[$], wr_cyc[$];
    int rd_addr[$], out_dat[$], out_cyc[$], done_cyc[$];

    logic [7:0] dmem [1024];
    logic [7:0] src_buf [8];
    int src_n = 0;
    int src_idx = 0;
    logic src_en = 1'b0;
    logic src_clr = 1'b0;
    int s;

    always #5 Clk = ~Clk;

    dm_burst_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgData(CfgData),
        .Start(Start), .Ptr(Ptr), .Len(Len), .Dir(Dir),
        .InData(InData), .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .DmAddr(DmAddr), .DmRdEn(DmRdEn), .DmWrEn(DmWrEn),
        .DmWrData(DmWrData), .DmRdData(DmRdData),
        .Busy(Busy), .Done(Done)
    );

    assign InValid = src_en && (src_idx < src_n);
    assign InData  = (src_idx < 8) ? src_buf[src_idx] : 8'h00;

    always @(posedge Clk) begin
        if (src_clr) src_idx <= 0;
        else if (InValid && InReady) src_idx <= src_idx + 1;
    end

    always @(posedge Clk) begin
        if (DmWrEn) dmem[DmAddr] <= DmWrData;
        DmRdData <= DmRdEn ? dmem[DmAddr] : 8'h00;
    end

    always @(negedge Clk) begin
        cyc++;
        if (DmWrEn) begin
            wr_addr.push_back(int'(DmAddr));
            wr_dat.push_back(int'(DmWrData));
            wr_cyc.push_back(cyc);
        end
        if (DmRdEn) rd_addr.push_back(int'(DmAddr));
        if (DmRdEn && DmWrEn) both_cnt++;
        if (OutValid && OutReady) begin
            out_dat.push_back(int'(OutData));
            out_cyc.push_back(cyc);
        end
        if (Done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        wr_addr.delete(); wr_dat.delete(); wr_cyc.delete();
        rd_addr.delete(); out_dat.delete(); out_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [9:0] d);
        CfgWe = 1'b1; CfgIdx = idx; CfgData = d;
        tick(1);
        CfgWe = 1'b0;
    endtask

    task automatic load(input logic [7:0] b0, input int n);
        for (int i = 0; i < 8; i++) src_buf[i] = b0 + 8'(i);
        src_n = n;
        src_en = 1'b1;
        src_clr = 1'b1;
        tick(1);
        src_clr = 1'b0;
    endtask

    task automatic start(input logic [1:0] p, input logic [7:0] l,
                         input logic d, output int sc);
        sc = cyc;
        Start = 1'b1; Ptr = p; Len = l; Dir = d;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done_cnt > d0) break;
        end
        chk(tag, 32'(done_cnt > d0), 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;
        for (int i = 0; i < 8; i++) src_buf[i] = 8'h00;
        dmem[50] = 8'd11; dmem[51] = 8'd22; dmem[52] = 8'd33;

        #1;
        chk("rst_outs", {Busy, Done, DmRdEn, DmWrEn, InReady, OutValid}, 0);
        chk("rst_bus", {DmAddr, OutData, DmWrData}, 0);
        tick(2);
        Reset = 1'b1;
        tick(1);

        cfg(1, 10'd100);
        load(8'hA0, 4);
        clr();
        start(1, 8'd4, 1'b1, s);
        wait_done("t1_done", 30);
        chk("t1_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", at(wr_addr, i), 100 + i);
            chk("t1_data", at(wr_dat, i), 'hA0 + i);
        end
        chk("t1_first", at(wr_cyc, 0), s + 2);
        chk("t1_consec", at(wr_cyc, 3) - at(wr_cyc, 0), 3);
        chk("t1_done_lat", at(done_cyc, 0), at(wr_cyc, 3) + 1);
        chk("t1_busy", Busy, 0);
        src_en = 1'b0;

        cfg(2, 10'd50);
        OutReady = 1'b1;
        clr();
        start(2, 8'd3, 1'b0, s);
        wait_done("t2_done", 30);
        chk("t2_nout", out_dat.size(), 3);
        chk("t2_d0", at(out_dat, 0), 11);
        chk("t2_d1", at(out_dat, 1), 22);
        chk("t2_d2", at(out_dat, 2), 33);
        chk("t2_consec", at(out_cyc, 2) - at(out_cyc, 0), 2);
        chk("t2_done_lat", at(done_cyc, 0), at(out_cyc, 2) + 1);
        chk("t2_raddr", at(rd_addr, 2), 52);

        OutReady = 1'b0;
        clr();
        start(2, 8'd3, 1'b0, s);
        tick(4);
        chk("t3_stall_rd", rd_addr.size(), 2);
        chk("t3_stall_out", out_dat.size(), 0);
        chk("t3_ovalid", OutValid, 1);
        OutReady = 1'b1;
        wait_done("t3_done", 30);
        chk("t3_nrd", rd_addr.size(), 3);
        chk("t3_nout", out_dat.size(), 3);
        chk("t3_d0", at(out_dat, 0), 11);
        chk("t3_d1", at(out_dat, 1), 22);
        chk("t3_d2", at(out_dat, 2), 33);

        cfg(3, 10'd1022);
        load(8'hB0, 4);
        clr();
        start(3, 8'd4, 1'b1, s);
        wait_done("t4_done", 30);
        chk("t4_a0", at(wr_addr, 0), 1022);
        chk("t4_a1", at(wr_addr, 1), 1023);
        chk("t4_a2", at(wr_addr, 2), 0);
        chk("t4_a3", at(wr_addr, 3), 1);
        chk("t4_mem0", dmem[0], 8'hB2);
        src_en = 1'b0;

        clr();
        start(0, 8'd0, 1'b0, s);
        wait_done("t5_done", 10);
        chk("t5_noacc", wr_addr.size() + rd_addr.size(), 0);
        chk("t5_lat", at(done_cyc, 0), s + 2);

        load(8'hC0, 3);
        clr();
        start(1, 8'd3, 1'b1, s);
        Start = 1'b1; Ptr = 2'd3; Len = 8'd1; Dir = 1'b0;
        CfgWe = 1'b1; CfgIdx = 2'd1; CfgData = 10'd200;
        tick(1);
        Start = 1'b0; CfgWe = 1'b0;
        wait_done("t5b_done", 30);
        tick(5);
        chk("t5b_ndone", done_cyc.size(), 1);
        chk("t5b_nrd", rd_addr.size(), 0);
        chk("t5b_nwr", wr_addr.size(), 3);
        chk("t5b_a0", at(wr_addr, 0), 100);
        chk("t5b_a2", at(wr_addr, 2), 102);
        chk("t5b_busy", Busy, 0);
        src_en = 1'b0;

        OutReady = 1'b0;
        clr();
        start(2, 8'd3, 1'b0, s);
        tick(2);
        chk("t6_busy", Busy, 1);
        #2 Reset = 1'b0;
        #1;
        chk("t6_outs", {Busy, Done, DmRdEn, DmWrEn, InReady, OutValid}, 0);
        chk("t6_bus", {DmAddr, OutData, DmWrData}, 0);
        tick(1);
        Reset = 1'b1;
        tick(1);
        chk("t6_idle", Busy, 0);
        cfg(2, 10'd50);
        OutReady = 1'b1;
        clr();
        start(2, 8'd3, 1'b0, s);
        wait_done("t6_done", 30);
        chk("t6_nout", out_dat.size(), 3);
        chk("t6_d0", at(out_dat, 0), 11);
        chk("t6_d2", at(out_dat, 2), 33);
        chk("t6_ndone", done_cyc.size(), 1);
        chk("both_en", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
